// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem responder.
// DMEM_RESP_RAND_LAT_EN selects per-request pseudo-random latency in the top level.
package dmem_resp_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } resp_state_e;

    // Counter is wide enough for the largest legal latency (15).
    localparam int CNT_W = 4;

    // Fibonacci LFSR with taps 8,6,5,4 (bits 7,5,4,3).
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// Word-addressed backing store: byte-strobed synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_resp_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] index,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    r_mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = r_mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one current slot plus one pending slot, FIFO completion
// after a fixed latency, or a pseudo-random latency when DMEM_RESP_RAND_LAT_EN is defined.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic                    dmem_write_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    input  logic                    dmem_read_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    err_o
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef struct packed {
        logic              write;
        logic [IDX_W-1:0]  index;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    resp_state_e      r_state, w_state_next;
    req_t             r_cur, w_cur_next;
    req_t             r_pend, w_pend_next;
    req_t             w_req_in;
    logic             r_pend_valid, w_pend_valid_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] w_lat_m1;
    logic             r_err, w_err_next;
    logic             w_req, w_done, w_drop, w_accept;
    logic [DATA_WIDTH-1:0] w_arr_rdata;
    logic             w_unused_addr;

    // Upper address bits alias onto the array; byte offset is ignored.
    assign w_unused_addr = ^{dmem_addr_i[ADDR_WIDTH-1:IDX_W+2], dmem_addr_i[1:0]};

    assign w_req    = dmem_read_i | dmem_write_i;
    assign w_req_in = '{write: dmem_write_i,
                        index: dmem_addr_i[IDX_W+1:2],
                        wdata: dmem_wdata_i,
                        wstrb: dmem_wstrb_i};

    assign w_done   = (r_state == BUSY) && (r_cnt == '0);
    assign w_drop   = w_req && (r_state == BUSY) && !w_done && r_pend_valid;
    assign w_accept = w_req && !w_drop;

`ifdef DMEM_RESP_RAND_LAT_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_lat_m1 = CNT_W'({24'd0, r_lfsr} % LATENCY);
`else
    assign w_lat_m1 = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        w_state_next      = r_state;
        w_cur_next        = r_cur;
        w_pend_next       = r_pend;
        w_pend_valid_next = r_pend_valid;
        w_cnt_next        = r_cnt;
        w_err_next        = r_err | w_drop | (dmem_read_i & dmem_write_i);

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cur_next   = w_req_in;
                    w_cnt_next   = w_lat_m1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_done) begin
                    if (r_pend_valid) begin
                        // Pending drains into current; a same-cycle request refills pending.
                        w_cur_next        = r_pend;
                        w_cnt_next        = w_lat_m1;
                        w_pend_valid_next = w_req;
                        if (w_req) begin
                            w_pend_next = w_req_in;
                        end
                    end else if (w_req) begin
                        w_cur_next = w_req_in;
                        w_cnt_next = w_lat_m1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                    if (w_req && !r_pend_valid) begin
                        w_pend_next       = w_req_in;
                        w_pend_valid_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cur        <= w_cur_next;
            r_pend       <= w_pend_next;
            r_pend_valid <= w_pend_valid_next;
            r_cnt        <= w_cnt_next;
            r_err        <= w_err_next;
        end
    end

    dmem_resp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (w_done & r_cur.write),
        .index (r_cur.index),
        .wdata (r_cur.wdata),
        .wstrb (r_cur.wstrb),
        .rdata (w_arr_rdata)
    );

    assign dmem_ready_o = w_done;
    assign dmem_rdata_o = (w_done && !r_cur.write) ? w_arr_rdata : '0;
    assign err_o        = r_err;

endmodule
